// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage shift unit (S1 operand register, OUT result register) with valid/ready handshakes
// Defining SHIFT_ROT_EN adds ROL/ROR as a two-pass P0/P1 sequence held in S1.
module shifter #(
  parameter int WIDTH = 32,
  parameter int SW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [SW-1:0]    sham,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] res
);
  logic signed [WIDTH-1:0] sra;
  assign sra = $signed(val) >>> sham;
  assign res = right ? (arith ? sra : val >> sham) : val << sham;
endmodule

module shift_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [WIDTH-1:0]         in_val,
  input  logic [$clog2(WIDTH)-1:0] in_sham,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int SW = $clog2(WIDTH);
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d, data_q, data_d, sh_res, res;
  logic [SW-1:0] sham_q, sham_d, sh_sham;
  logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic done, right, arith, out_adv, s1_moves, accept;
  assign out_adv = !out_valid_q || out_ready;
  assign s1_moves = s1_valid_q && out_adv && done;
  assign in_ready = rst_n && !flush && (!s1_valid_q || s1_moves);
  assign accept = in_valid && in_ready;
`ifdef SHIFT_ROT_EN
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
  logic phase_q, phase_d, rot;
  logic [WIDTH-1:0] part_q, part_d;
  assign rot = op_q[2] && !op_q[1];
  assign done = !rot || phase_q == P1;
  // P1 shifts the opposite way by (WIDTH - sham) mod WIDTH, which is -sham in SW bits
  assign right = rot ? op_q[0] ^ phase_q : !op_q[2] && op_q[0];
  assign arith = op_q == 3'b011;
  assign sh_sham = phase_q == P1 ? -sham_q : sham_q;
  assign res = phase_q == P1 ? sh_res | part_q : sh_res;
  always_comb begin
    phase_d = (flush || !s1_valid_q) ? P0 : (rot && phase_q == P0) ? P1 : s1_moves ? P0 : phase_q;
    part_d = (s1_valid_q && rot && phase_q == P0) ? sh_res : part_q;
  end
  always_ff @(posedge clk) begin
    phase_q <= rst_n ? phase_d : P0;
    part_q <= rst_n ? part_d : '0;
  end
`else
  logic unused_op2;
  assign unused_op2 = op_q[2];
  assign done = 1'b1;
  assign right = op_q[0];
  assign arith = op_q[1:0] == 2'b11;
  assign sh_sham = sham_q;
  assign res = sh_res;
`endif
  shifter #(.WIDTH(WIDTH)) u_shifter (
    .val(val_q), .sham(sh_sham), .right(right), .arith(arith), .res(sh_res)
  );
  always_comb begin
    op_d = accept ? in_op : op_q;
    val_d = accept ? in_val : val_q;
    sham_d = accept ? in_sham : sham_q;
    tag_d = accept ? in_tag : tag_q;
    s1_valid_d = !flush && (accept || (s1_valid_q && !s1_moves));
    out_valid_d = !flush && (out_adv ? s1_moves : out_valid_q);
    data_d = s1_moves ? res : data_q;
    otag_d = s1_moves ? tag_q : otag_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= '0;
      val_q <= '0;
      sham_q <= '0;
      tag_q <= '0;
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      data_q <= '0;
      otag_q <= '0;
    end else begin
      op_q <= op_d;
      val_q <= val_d;
      sham_q <= sham_d;
      tag_q <= tag_d;
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      data_q <= data_d;
      otag_q <= otag_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = data_q;
  assign out_tag = otag_q;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: directed vectors for shift_exec_stage against a queue-based reference model
`timescale 1ns/1ps
module tb_shift_exec_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [2:0] in_op = 3'd0;
  logic [31:0] in_val = 32'd0, out_data;
  logic [4:0] in_sham = 5'd0, in_tag = 5'd0, out_tag;
  int checks = 0, errors = 0, cyc = 0;
  logic [36:0] exp_q[$];
  int log_cyc[$];
  int log_tag[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_d = 32'd0;
  logic [4:0] prev_t = 5'd0;
  bit streaming;
`ifdef SHIFT_ROT_EN
  localparam logic [31:0] ROR_EXP = 32'h1000_000F;
  localparam logic [31:0] ROL_EXP = 32'h0000_0003;
  localparam int ROT_LAT = 3;
`else
  localparam logic [31:0] ROR_EXP = 32'h0000_000F;
  localparam logic [31:0] ROL_EXP = 32'h0000_0002;
  localparam int ROT_LAT = 2;
`endif

  always #5 clk = ~clk;

  shift_exec_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_val(in_val), .in_sham(in_sham), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] v, input logic [4:0] s);
    logic [63:0] d;
    logic signed [31:0] sv;
    logic [2:0] e;
    d = {v, v};
    sv = v;
`ifdef SHIFT_ROT_EN
    e = op;
`else
    e = {1'b0, op[1:0]};
`endif
    case (e)
      3'b001: return v >> s;
      3'b011: return sv >>> s;
      3'b100: begin d = d << s; return d[63:32]; end
      3'b101: begin d = d >> s; return d[31:0]; end
      default: return v << s;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  // starts and ends just after a rising edge; returns once the op has been taken
  task automatic send(input logic [2:0] op, input logic [31:0] v, input logic [4:0] s, input logic [4:0] t);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_val = v; in_sham = s; in_tag = t;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chkb($sformatf("send_tag%0d_ready", t), in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat(input string nm, input int want, input logic [31:0] d, input logic [4:0] t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk({nm, "_lat"}, 32'(n), 32'(want));
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_tag"}, 32'(out_tag), 32'(t));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // scoreboard: every consumed result must match the oldest live accepted op
  always @(negedge clk) begin
    logic [36:0] e;
    cyc++;
    if (prev_stall) begin
      checks++;
      if (!out_valid || out_data !== prev_d || out_tag !== prev_t) begin
        errors++;
        $display("FAIL stall_hold got %b %h/%0d want 1 %h/%0d", out_valid, out_data, out_tag, prev_d, prev_t);
      end
    end
    if (!rst_n || flush) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_blocked got %b want 0", in_ready);
      end
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out got tag %0d data %h want none", out_tag, out_data);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          if ({out_tag, out_data} !== e) begin
            errors++;
            $display("FAIL result got %0d/%h want %0d/%h", out_tag, out_data, e[36:32], e[31:0]);
          end
          log_cyc.push_back(cyc);
          log_tag.push_back(int'(out_tag));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_tag, model(in_op, in_val, in_sham)});
    end
    prev_stall = rst_n && !flush && out_valid && !out_ready;
    prev_d = out_data;
    prev_t = out_tag;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    logic [2:0] ops [7];
    int k;
    pat = 16'b1011_0110_1101_0011;
    ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chkb("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("model_sra", model(3'b011, 32'h8000_0000, 5'd4), 32'hF800_0000);
    chk("model_ror", model(3'b101, 32'h0000_00F1, 5'd4), ROR_EXP);
    chk("model_rol", model(3'b100, 32'h8000_0001, 5'd1), ROL_EXP);
    send(3'b011, 32'h8000_0000, 5'd4, 5'd1); lat("sra", 2, 32'hF800_0000, 5'd1);
    send(3'b001, 32'h8000_0000, 5'd4, 5'd2); lat("srl", 2, 32'h0800_0000, 5'd2);
    send(3'b000, 32'h0000_0001, 5'd31, 5'd3); lat("sll31", 2, 32'h8000_0000, 5'd3);
    send(3'b001, 32'h8000_0000, 5'd31, 5'd4); lat("srl31", 2, 32'h0000_0001, 5'd4);
    send(3'b000, 32'h1234_5678, 5'd0, 5'd5); lat("sll0", 2, 32'h1234_5678, 5'd5);
    send(3'b101, 32'h0000_00F1, 5'd4, 5'd6); lat("ror4", ROT_LAT, ROR_EXP, 5'd6);
    send(3'b100, 32'h8000_0001, 5'd1, 5'd7); lat("rol1", ROT_LAT, ROL_EXP, 5'd7);
    send(3'b101, 32'h1234_5678, 5'd0, 5'd8); lat("ror0", ROT_LAT, 32'h1234_5678, 5'd8);
    drain();
    log_cyc.delete(); log_tag.delete();
    send(3'b011, 32'hC000_0000, 5'd1, 5'd1);
    send(3'b000, 32'h0000_00FF, 5'd8, 5'd2);
    send(3'b001, 32'hFFFF_0000, 5'd16, 5'd3);
    drain();
    chk("abc_count", 32'(log_tag.size()), 32'd3);
    if (log_tag.size() == 3) begin
      chk("abc_tags", 32'(log_tag[0] * 100 + log_tag[1] * 10 + log_tag[2]), 32'd123);
      chk("abc_back_to_back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end
    log_cyc.delete(); log_tag.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b000; in_val = 32'h11; in_sham = 5'd1; in_tag = 5'd4;
    @(negedge clk); chkb("stall_rdy0", in_ready, 1'b1);
    @(posedge clk); #1 in_op = 3'b001; in_val = 32'h22; in_tag = 5'd5;
    @(negedge clk); chkb("stall_rdy1", in_ready, 1'b1);
    @(posedge clk); #1 in_op = 3'b011; in_val = 32'h8000_0033; in_tag = 5'd6;
    @(negedge clk); chkb("stall_rdy2", in_ready, 1'b0); chk("stall_head_tag", 32'(out_tag), 32'd4);
    @(posedge clk); #1;
    @(negedge clk); chkb("stall_rdy3", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chkb("stall_rdy4", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    chk("stall_count", 32'(log_tag.size()), 32'd3);
    if (log_tag.size() == 3) chk("stall_tags", 32'(log_tag[0] * 100 + log_tag[1] * 10 + log_tag[2]), 32'd456);
    out_ready = 1'b0;
    send(3'b000, 32'h7, 5'd2, 5'd7);
    send(3'b001, 32'h80, 5'd3, 5'd8);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'b000; in_val = 32'h1; in_sham = 5'd0; in_tag = 5'd10;
    @(negedge clk); chkb("flush_rdy", in_ready, 1'b0); chkb("flush_out_full", out_valid, 1'b1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); chkb("flush_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    send(3'b001, 32'hF0, 5'd4, 5'd9); lat("post_flush", 2, 32'h0F, 5'd9);
    drain();
    streaming = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send(ops[i % 7], 32'hDEAD_BEEF ^ (32'(i) * 32'h9E37_79B9), 5'(i * 7), 5'(i));
        streaming = 1'b0;
      end
      begin
        k = 0;
        while (streaming) begin
          @(posedge clk); #1 out_ready = pat[k % 16];
          k++;
        end
      end
    join
    drain();
    out_ready = 1'b0;
    send(3'b011, 32'hF000_0000, 5'd8, 5'd11);
    send(3'b000, 32'h3, 5'd5, 5'd12);
    rst_n = 1'b0; in_valid = 1'b1; in_tag = 5'd13;
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chkb("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    repeat (4) @(negedge clk);
    chkb("midrst_no_stale", out_valid, 1'b0);
    @(posedge clk); #1;
    send(3'b100, 32'h8000_0001, 5'd1, 5'd14); lat("post_rst", ROT_LAT, ROL_EXP, 5'd14);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
